hazard_ctrl_unit: RTL

Parametrised successor to the pipeline stall/flush controller for the 5-stage RV32I core.
- Generates per-stage stall/flush controls.
- Supports configurable data-memory latency and multi-cycle EX operations (mul/div) through a busy/done handshake.
- Optional forwarding mode (operand-select outputs; stalls only on load-use).
- Saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_ctrl_unit_if.sv | 69 ++++++
 rtl/mem_wait_ctr.sv | 51 +++++
 rtl/hazard_ctrl_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the interface, the wait counter and the top level.
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // x0 is hardwired to zero, so it never carries a dependency
    function automatic logic rd_hit(
        input logic              wren,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs
    );
        return wren && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-to-hazard-unit bundle: stage register tags in,
// stage stall/flush controls, forwarding selects and counters out.
interface hazard_ctrl_unit_if #(
    parameter int CNT_W = 32
);
    import hazard_pkg::*;

    logic [REG_AW-1:0] i_ID_rs1_addr;
    logic [REG_AW-1:0] i_ID_rs2_addr;
    logic [REG_AW-1:0] i_EX_rs1_addr;
    logic [REG_AW-1:0] i_EX_rs2_addr;
    logic              i_EX_pc_sel;
    logic              i_EX_rd_wren;
    logic [REG_AW-1:0] i_EX_rd_addr;
    logic              i_EX_is_load;
    logic              i_EX_mc_valid;
    logic              i_EX_mc_done;
    logic              i_MEM_rd_wren;
    logic [REG_AW-1:0] i_MEM_rd_addr;
    logic              i_MEM_mem_req;
    logic              i_WB_rd_wren;
    logic [REG_AW-1:0] i_WB_rd_addr;
    logic              i_cnt_clr;

    logic              o_pc_stall;
    logic              o_IF_ID_stall;
    logic              o_IF_ID_flush;
    logic              o_ID_EX_stall;
    logic              o_ID_EX_flush;
    logic              o_EX_MEM_stall;
    logic              o_EX_MEM_flush;
    logic              o_MEM_WB_stall;
    logic              o_MEM_WB_flush;
    logic [1:0]        o_fwd_rs1_sel;
    logic [1:0]        o_fwd_rs2_sel;
    logic [CNT_W-1:0]  o_stall_cycles;
    logic [CNT_W-1:0]  o_flush_events;

    modport master (
        output i_ID_rs1_addr, i_ID_rs2_addr,
        output i_EX_rs1_addr, i_EX_rs2_addr,
        output i_EX_pc_sel, i_EX_rd_wren, i_EX_rd_addr,
        output i_EX_is_load, i_EX_mc_valid, i_EX_mc_done,
        output i_MEM_rd_wren, i_MEM_rd_addr, i_MEM_mem_req,
        output i_WB_rd_wren, i_WB_rd_addr, i_cnt_clr,
        input  o_pc_stall, o_IF_ID_stall, o_IF_ID_flush,
        input  o_ID_EX_stall, o_ID_EX_flush,
        input  o_EX_MEM_stall, o_EX_MEM_flush,
        input  o_MEM_WB_stall, o_MEM_WB_flush,
        input  o_fwd_rs1_sel, o_fwd_rs2_sel,
        input  o_stall_cycles, o_flush_events
    );

    modport slave (
        input  i_ID_rs1_addr, i_ID_rs2_addr,
        input  i_EX_rs1_addr, i_EX_rs2_addr,
        input  i_EX_pc_sel, i_EX_rd_wren, i_EX_rd_addr,
        input  i_EX_is_load, i_EX_mc_valid, i_EX_mc_done,
        input  i_MEM_rd_wren, i_MEM_rd_addr, i_MEM_mem_req,
        input  i_WB_rd_wren, i_WB_rd_addr, i_cnt_clr,
        output o_pc_stall, o_IF_ID_stall, o_IF_ID_flush,
        output o_ID_EX_stall, o_ID_EX_flush,
        output o_EX_MEM_stall, o_EX_MEM_flush,
        output o_MEM_WB_stall, o_MEM_WB_flush,
        output o_fwd_rs1_sel, o_fwd_rs2_sel,
        output o_stall_cycles, o_flush_events
    );

endinterface

// File: rtl/mem_wait_ctr.sv
// Data-memory wait sequencer: holds the pipeline for MEM_LATENCY-1
// cycles per memory op, then gives one release cycle.
module mem_wait_ctr
    import hazard_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic mem_req_i,
    output logic wait_stall_o
);

    localparam int W  = MEM_LATENCY - 1;
    localparam int CW = $clog2(MEM_LATENCY) + 1;
    localparam logic [CW-1:0] RELOAD = (W >= 1) ? CW'(W - 1) : '0;

    hz_state_e      state_q;
    logic [CW-1:0]  cnt_q;

    // The release cycle is spent in ST_MEM_WAIT, so a request still
    // held high by the frozen MEM stage cannot start a new wait.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_req_i && (W >= 1)) begin
                        state_q <= ST_MEM_WAIT;
                        cnt_q   <= RELOAD;
                    end
                end
                ST_MEM_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign wait_stall_o = (W >= 1) &&
        (((state_q == ST_RUN) && mem_req_i) ||
         ((state_q == ST_MEM_WAIT) && (cnt_q != '0)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush controller for the 5-stage RV32I pipeline with optional
// forwarding, memory wait states, multi-cycle EX and perf counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter bit FORWARDING  = 1'b0,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    hazard_ctrl_unit_if.slave bus
);

    logic mem_stall;
    logic mc_stall;
    logic hi_stall;
    logic br_flush;
    logic raw_any;
    logic raw_load;
    logic haz_stall;
    logic pc_stall;
    logic mem_h1, mem_h2, wb_h1, wb_h2;

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    mem_wait_ctr #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_mem_wait (
        .clk_i        (i_clk),
        .rst_ni       (i_reset),
        .mem_req_i    (bus.i_MEM_mem_req),
        .wait_stall_o (mem_stall)
    );

    assign mc_stall = bus.i_EX_mc_valid & ~bus.i_EX_mc_done;
    assign hi_stall = mem_stall | mc_stall;

    // A frozen EX keeps pc_sel high, so the flush lands once, unstalled
    assign br_flush = bus.i_EX_pc_sel & ~hi_stall;

    assign raw_any =
        rd_hit(bus.i_EX_rd_wren,  bus.i_EX_rd_addr,  bus.i_ID_rs1_addr) |
        rd_hit(bus.i_EX_rd_wren,  bus.i_EX_rd_addr,  bus.i_ID_rs2_addr) |
        rd_hit(bus.i_MEM_rd_wren, bus.i_MEM_rd_addr, bus.i_ID_rs1_addr) |
        rd_hit(bus.i_MEM_rd_wren, bus.i_MEM_rd_addr, bus.i_ID_rs2_addr) |
        rd_hit(bus.i_WB_rd_wren,  bus.i_WB_rd_addr,  bus.i_ID_rs1_addr) |
        rd_hit(bus.i_WB_rd_wren,  bus.i_WB_rd_addr,  bus.i_ID_rs2_addr);

    assign raw_load = bus.i_EX_is_load & (
        rd_hit(1'b1, bus.i_EX_rd_addr, bus.i_ID_rs1_addr) |
        rd_hit(1'b1, bus.i_EX_rd_addr, bus.i_ID_rs2_addr));

    assign haz_stall = (FORWARDING ? raw_load : raw_any) &
                       ~hi_stall & ~bus.i_EX_pc_sel;

    assign pc_stall = hi_stall | haz_stall;

    assign bus.o_pc_stall     = i_reset & pc_stall;
    assign bus.o_IF_ID_stall  = i_reset & pc_stall;
    assign bus.o_IF_ID_flush  = i_reset & br_flush;
    assign bus.o_ID_EX_stall  = i_reset & hi_stall;
    assign bus.o_ID_EX_flush  = i_reset & (br_flush | haz_stall);
    assign bus.o_EX_MEM_stall = i_reset & mem_stall;
    assign bus.o_EX_MEM_flush = i_reset & mc_stall & ~mem_stall;
    assign bus.o_MEM_WB_stall = 1'b0;
    assign bus.o_MEM_WB_flush = i_reset & mem_stall;

    assign mem_h1 = rd_hit(bus.i_MEM_rd_wren, bus.i_MEM_rd_addr,
                           bus.i_EX_rs1_addr);
    assign mem_h2 = rd_hit(bus.i_MEM_rd_wren, bus.i_MEM_rd_addr,
                           bus.i_EX_rs2_addr);
    assign wb_h1  = rd_hit(bus.i_WB_rd_wren, bus.i_WB_rd_addr,
                           bus.i_EX_rs1_addr);
    assign wb_h2  = rd_hit(bus.i_WB_rd_wren, bus.i_WB_rd_addr,
                           bus.i_EX_rs2_addr);

    // MEM holds the younger value, so it wins over WB
    assign bus.o_fwd_rs1_sel = (!FORWARDING || !i_reset) ? FWD_RF :
                               mem_h1 ? FWD_MEM :
                               wb_h1  ? FWD_WB  : FWD_RF;
    assign bus.o_fwd_rs2_sel = (!FORWARDING || !i_reset) ? FWD_RF :
                               mem_h2 ? FWD_MEM :
                               wb_h2  ? FWD_WB  : FWD_RF;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (bus.i_cnt_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (pc_stall && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
            if (br_flush && !(&flush_q)) flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.o_stall_cycles = stall_q;
    assign bus.o_flush_events = flush_q;

endmodule
